// File: rtl/bz_pll_reset_ctrl.sv
// PLL reset sequencer on the free-running reference clock: resets the PLL, qualifies
// lock, retries on timeout, and hands a core reset request plus status to the core domain.
module bz_pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             sw_relock,
    output logic             pll_rst,
    output logic             core_rst,
    output logic             ready,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TO_LAST  = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STB_LAST = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CYC_W-1:0] cyc_reg;
    logic [CYC_W-1:0] cyc_next;
    logic [1:0]       sync_reg;
    logic             lk_s;
    logic             relock_inc;
    logic             timeout_inc;

    // pll_locked comes from the PLL with no relation to refclk
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign lk_s = sync_reg[1];

    always_comb begin
        state_next  = state_reg;
        cyc_next    = cyc_reg + CYC_W'(1);
        relock_inc  = 1'b0;
        timeout_inc = 1'b0;
        if (sw_relock) begin
            state_next = RESET_PLL;
        end else begin
            case (state_reg)
                RESET_PLL: begin
                    if (cyc_reg == RST_LAST) state_next = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_next = STABLE;
                    end else if (cyc_reg == TO_LAST) begin
                        state_next  = RESET_PLL;
                        timeout_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lk_s) begin
                        state_next = WAIT_LOCK;
                    end else if (cyc_reg == STB_LAST) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    cyc_next = '0;
                    if (!lk_s) begin
                        state_next = RESET_PLL;
                        relock_inc = 1'b1;
                    end
                end
                default: state_next = RESET_PLL;
            endcase
        end
        // sw_relock in RESET_PLL keeps the state but must still restart the count
        if (sw_relock || (state_next != state_reg)) cyc_next = '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_PLL;
            cyc_reg       <= '0;
            pll_rst       <= 1'b1;
            core_rst      <= 1'b1;
            ready         <= 1'b0;
            relock_count  <= '0;
            timeout_count <= '0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            pll_rst   <= (state_next == RESET_PLL);
            core_rst  <= (state_next != RUN);
            ready     <= (state_next == RUN);
            if (relock_inc && (relock_count != CNT_MAX)) begin
                relock_count <= relock_count + CNT_W'(1);
            end
            if (timeout_inc && (timeout_count != CNT_MAX)) begin
                timeout_count <= timeout_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bz_pll_reset_ctrl.sv
// Bench for bz_pll_reset_ctrl: directed vector table, hand sequences and random
// stimulus, every cycle compared against a phase/elapsed-time reference model.
module tb_bz_pll_reset_ctrl;

    localparam int PR  = 4;
    localparam int LT  = 20;
    localparam int SC  = 8;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;

    logic          refclk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          sw_relock;
    logic          pll_rst;
    logic          core_rst;
    logic          ready;
    logic [CW-1:0] relock_count;
    logic [CW-1:0] timeout_count;

    always #5 refclk = ~refclk;

    bz_pll_reset_ctrl #(
        .PLL_RST_CYCLES(PR),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .CNT_W         (CW)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_relock    (sw_relock),
        .pll_rst      (pll_rst),
        .core_rst     (core_rst),
        .ready        (ready),
        .relock_count (relock_count),
        .timeout_count(timeout_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc_no   = 0;
    bit saw_ready;

    // Reference model: which phase we are in and how long we have been there.
    int m_phase;
    int m_elapsed;
    int m_relock;
    int m_timeout;
    bit m_h0;
    bit m_h1;

    typedef struct {
        bit locked;
        bit pulse;
        int cycles;
        bit e_pll_rst;
        bit e_core_rst;
        bit e_ready;
        int e_relock;
        int e_timeout;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc_no, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_phase   = P_RST;
        m_elapsed = 0;
        m_relock  = 0;
        m_timeout = 0;
        m_h0      = 1'b0;
        m_h1      = 1'b0;
    endtask

    task automatic enter(input int p);
        m_phase   = p;
        m_elapsed = 0;
    endtask

    // The FSM decides on what pll_locked was two edges earlier.
    task automatic model_step();
        bit lk;
        lk   = m_h1;
        m_h1 = m_h0;
        m_h0 = pll_locked;
        if (sw_relock) begin
            enter(P_RST);
        end else begin
            case (m_phase)
                P_RST: begin
                    m_elapsed++;
                    if (m_elapsed == PR) enter(P_WAIT);
                end
                P_WAIT: begin
                    if (lk) begin
                        enter(P_STAB);
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == LT) begin
                            enter(P_RST);
                            if (m_timeout < SAT) m_timeout++;
                        end
                    end
                end
                P_STAB: begin
                    if (!lk) begin
                        enter(P_WAIT);
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == SC) enter(P_RUN);
                    end
                end
                default: begin
                    if (!lk) begin
                        enter(P_RST);
                        if (m_relock < SAT) m_relock++;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_model();
        check("pll_rst", pll_rst, 32'(m_phase == P_RST));
        check("core_rst", core_rst, 32'(m_phase != P_RUN));
        check("ready", ready, 32'(m_phase == P_RUN));
        check("relock_count", relock_count, m_relock);
        check("timeout_count", timeout_count, m_timeout);
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        cyc_no++;
        if (ready) saw_ready = 1'b1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge refclk);
        rst_n = 1'b0;
        model_reset();
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_no);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;

        vecs[0]  = '{1'b1, 1'b0, 12, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1, 0};
        vecs[6]  = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, 19, 1'b0, 1'b1, 1'b0, 1, 0};
        vecs[8]  = '{1'b0, 1'b0, 1,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[9]  = '{1'b1, 1'b0, 4,  1'b0, 1'b1, 1'b0, 1, 1};
        vecs[10] = '{1'b1, 1'b0, 5,  1'b0, 1'b1, 1'b0, 1, 1};
        vecs[11] = '{1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1, 1};
        vecs[12] = '{1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1, 1};
        vecs[13] = '{1'b1, 1'b0, 8,  1'b0, 1'b1, 1'b0, 1, 1};
        vecs[14] = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b1, 1, 1};
        vecs[15] = '{1'b1, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[16] = '{1'b1, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[17] = '{1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1, 1};
        vecs[18] = '{1'b1, 1'b0, 9,  1'b0, 1'b0, 1'b1, 1, 1};
        vecs[19] = '{1'b0, 1'b0, 2,  1'b0, 1'b0, 1'b1, 1, 1};
        vecs[20] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[21] = '{1'b0, 1'b0, 2,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[22] = '{1'b0, 1'b1, 1,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[23] = '{1'b0, 1'b0, 3,  1'b1, 1'b1, 1'b0, 1, 1};
        vecs[24] = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 1, 1};

        rst_n      = 1'b0;
        pll_locked = 1'b1;
        sw_relock  = 1'b0;
        saw_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge refclk);
        check("reset_pll_rst", pll_rst, 1);
        check("reset_core_rst", core_rst, 1);
        check("reset_ready", ready, 0);
        check("reset_relock", relock_count, 0);
        check("reset_timeout", timeout_count, 0);
        rst_n = 1'b1;

        // Directed table: power-up, lock loss in RUN, timeout, STABLE dropout, sw_relock cases
        for (int i = 0; i < 25; i++) begin
            pll_locked = vecs[i].locked;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                sw_relock = vecs[i].pulse && (c == 0);
                tick();
            end
            sw_relock = 1'b0;
            check($sformatf("row%0d_pll_rst", i), pll_rst, vecs[i].e_pll_rst);
            check($sformatf("row%0d_core_rst", i), core_rst, vecs[i].e_core_rst);
            check($sformatf("row%0d_ready", i), ready, vecs[i].e_ready);
            check($sformatf("row%0d_relock", i), relock_count, vecs[i].e_relock);
            check($sformatf("row%0d_timeout", i), timeout_count, vecs[i].e_timeout);
            $display("row %0d: locked=%0b pulse=%0b cycles=%0d -> pll_rst=%0b core_rst=%0b ready=%0b relock=%0d timeout=%0d",
                     i, vecs[i].locked, vecs[i].pulse, vecs[i].cycles,
                     pll_rst, core_rst, ready, relock_count, timeout_count);
        end

        // Async reset in the middle of WAIT_LOCK with timeout_count=3
        repeat (48) tick();
        check("midwait_timeout", timeout_count, 3);
        check("midwait_pll_rst", pll_rst, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_pll_rst", pll_rst, 1);
        check("async_core_rst", core_rst, 1);
        check("async_ready", ready, 0);
        check("async_relock", relock_count, 0);
        check("async_timeout", timeout_count, 0);
        $display("async reset: pll_rst=%0b core_rst=%0b ready=%0b relock=%0d timeout=%0d",
                 pll_rst, core_rst, ready, relock_count, timeout_count);
        @(negedge refclk);
        rst_n      = 1'b1;
        pll_locked = 1'b1;
        repeat (PR - 1) tick();
        check("restart_pll_rst_hold", pll_rst, 1);
        tick();
        check("restart_pll_rst_fall", pll_rst, 0);

        // Locked held low: timeout_count saturates, ready never rises
        pll_locked = 1'b0;
        do_reset();
        saw_ready = 1'b0;
        repeat (SAT * (PR + LT) - 1) tick();
        check("timeout_pre_sat", timeout_count, SAT - 1);
        tick();
        check("timeout_at_sat", timeout_count, SAT);
        repeat (2 * (PR + LT)) tick();
        check("timeout_held_sat", timeout_count, SAT);
        check("ready_never_rose", 32'(saw_ready), 0);
        $display("timeout saturation: timeout=%0d ready_seen=%0b", timeout_count, saw_ready);

        // Repeated lock loss in RUN: relock_count saturates
        pll_locked = 1'b1;
        do_reset();
        for (int i = 0; i < SAT + 1; i++) begin
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                tick();
                got = ready;
            end
            check("relock_wait_ready", 32'(got), 1);
            pll_locked = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                got = !ready;
            end
            check("relock_wait_drop", 32'(got), 1);
            pll_locked = 1'b1;
            if (i == SAT - 1) check("relock_at_sat", relock_count, SAT);
        end
        check("relock_held_sat", relock_count, SAT);
        $display("relock saturation: relock=%0d", relock_count);

        // Random lock behaviour and sw_relock pulses against the model
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            pll_locked = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 40);
            for (int c = 0; c < len; c++) begin
                sw_relock = ($urandom_range(0, 63) == 0);
                tick();
            end
        end
        sw_relock = 1'b0;
        $display("random: cycles=%0d relock=%0d timeout=%0d", cyc_no, relock_count, timeout_count);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
